dispatch_sched: RTL and testbench

DISPATCH_SCHED -- requirements
Module: dispatch_sched

---
 rtl/pipeline_defines.sv | 19 +
 rtl/dispatch_sched_scoreboard.sv | 59 +++++
 rtl/dispatch_sched.sv | 139 +++++++++++++
 tb/tb_dispatch_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defines.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_defines (package)
//  Description : Shared types and constants for the dispatch scheduler:
//                scheduler state encoding and architectural register counts.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_defines;

    localparam int c_NUM_REGS = 32;
    localparam int c_REG_AW   = 5;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } dispatch_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/dispatch_sched_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_sched_scoreboard
//  Description : Register busy-bit scoreboard. Two set ports (issuing
//                writers), two clear ports (writeback), a flush-clear and
//                four read ports. r0 is never busy. A set beats a clear of
//                the same register; a flush clears everything and drops sets.
//  Revision    : 1.0 - initial release
// ============================================================================
module dispatch_sched_scoreboard
    import pipeline_defines::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               i_set_valid,
    input  logic [1:0][c_REG_AW-1:0] i_set_addr,
    input  logic [1:0]               i_clr_valid,
    input  logic [1:0][c_REG_AW-1:0] i_clr_addr,
    input  logic                     i_flush,
    input  logic [3:0][c_REG_AW-1:0] i_rd_addr,
    output logic [3:0]               o_rd_busy
);

    logic [c_NUM_REGS-1:0] r_busy;
    logic [c_NUM_REGS-1:0] w_set;
    logic [c_NUM_REGS-1:0] w_clr;
    logic [c_NUM_REGS-1:0] w_busy_nxt;

    // Decode set/clear strobes and form the next busy vector (set beats clear)
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int k = 0; k < 2; k++) begin
            if (i_set_valid[k]) w_set[i_set_addr[k]] = 1'b1;
            if (i_clr_valid[k]) w_clr[i_clr_addr[k]] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy vector register; flush wipes it and suppresses same-cycle sets
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read ports: registered state only, no writeback bypass
    always_comb begin
        o_rd_busy = '0;
        for (int p = 0; p < 4; p++) begin
            o_rd_busy[p] = r_busy[i_rd_addr[p]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dispatch_sched.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_sched
//  Description : Dual-slot in-order issue controller. Grants issue per slot
//                from scoreboard hazards, intra-pair conflicts, EXE stall and
//                a post-flush drain window (RUN/DRAIN FSM).
//                Optional macro DISPATCH_SCHED_PERF_EN adds stall_cycles_o,
//                a saturating count of cycles where slot 0 is valid but held.
//  Revision    : 1.0 - initial release
// ============================================================================
module dispatch_sched
    import pipeline_defines::*;
#(
    parameter int DECODE_WIDTH = 2,
    parameter int FLUSH_DRAIN  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DECODE_WIDTH-1:0]              id_valid_i,
    input  logic [DECODE_WIDTH-1:0][1:0]         id_reg_read_valid_i,
    input  logic [DECODE_WIDTH-1:0][9:0]         id_reg_read_addr_i,
    input  logic [DECODE_WIDTH-1:0]              id_reg_write_valid_i,
    input  logic [DECODE_WIDTH-1:0][c_REG_AW-1:0] id_reg_write_addr_i,
    input  logic                                 ex_stall_i,
    input  logic                                 flush_i,
    input  logic [1:0]                           wb_valid_i,
    input  logic [1:0][c_REG_AW-1:0]             wb_addr_i,
    output logic [DECODE_WIDTH-1:0]              issue_o
`ifdef DISPATCH_SCHED_PERF_EN
    ,
    output logic [31:0]                          stall_cycles_o
`endif
);

    localparam int                 c_CNT_W    = (FLUSH_DRAIN > 1) ? $clog2(FLUSH_DRAIN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FLUSH_DRAIN - 1);

    dispatch_sched_state_t r_state;
    dispatch_sched_state_t w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;

    logic [3:0][c_REG_AW-1:0] w_rd_addr;
    logic [3:0]               w_rd_busy;
    logic [1:0]               w_haz;
    logic                     w_pair_conflict;
    logic [1:0]               w_set_valid;

    // Source order on the read ports: slot0 src1, slot0 src2, slot1 src1, slot1 src2
    assign w_rd_addr = {id_reg_read_addr_i[1][9:5], id_reg_read_addr_i[1][4:0],
                        id_reg_read_addr_i[0][9:5], id_reg_read_addr_i[0][4:0]};

    // Per-slot source hazard: enabled, nonzero address and busy
    always_comb begin
        w_haz = '0;
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < 2; j++) begin
                if (id_reg_read_valid_i[s][j] && (w_rd_addr[2*s+j] != '0) && w_rd_busy[2*s+j])
                    w_haz[s] = 1'b1;
            end
        end
    end

    // Slot 1 must not read or rewrite a nonzero rd produced by slot 0 this cycle
    always_comb begin
        w_pair_conflict = 1'b0;
        if (id_reg_write_valid_i[0] && (id_reg_write_addr_i[0] != '0)) begin
            if ((id_reg_read_valid_i[1][0] && (w_rd_addr[2] == id_reg_write_addr_i[0])) ||
                (id_reg_read_valid_i[1][1] && (w_rd_addr[3] == id_reg_write_addr_i[0])) ||
                (id_reg_write_valid_i[1]   && (id_reg_write_addr_i[1] == id_reg_write_addr_i[0])))
                w_pair_conflict = 1'b1;
        end
    end

    // FSM next state, drain counter next value and in-order issue grants
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        issue_o     = '0;
        if (r_state == ST_RUN) begin
            if (flush_i) begin
                w_state_nxt = ST_DRAIN;
                w_cnt_nxt   = c_CNT_LOAD;
            end
        end else begin
            if (flush_i) begin
                w_cnt_nxt = c_CNT_LOAD;
            end else if (r_cnt == '0) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
        end
        issue_o[0] = !rst && id_valid_i[0] && !w_haz[0] && !ex_stall_i && (r_state == ST_RUN);
        issue_o[1] = issue_o[0] && id_valid_i[1] && !w_haz[1] && !w_pair_conflict;
    end

    // State and drain counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_set_valid = issue_o[1:0] & id_reg_write_valid_i[1:0];

    dispatch_sched_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_set_valid (w_set_valid),
        .i_set_addr  (id_reg_write_addr_i[1:0]),
        .i_clr_valid (wb_valid_i),
        .i_clr_addr  (wb_addr_i),
        .i_flush     (flush_i),
        .i_rd_addr   (w_rd_addr),
        .o_rd_busy   (w_rd_busy)
    );

`ifdef DISPATCH_SCHED_PERF_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of cycles where slot 0 holds an instruction but is not granted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (id_valid_i[0] && !issue_o[0] && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dispatch_sched
//  Description : Self-checking bench for dispatch_sched: vector table,
//                hand-written corner sequences and random traffic against a
//                behavioural model (busy array + remaining-drain count).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_sched;

    localparam int FD = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      id_valid;
    logic [1:0][1:0] rv;
    logic [1:0][9:0] ra;
    logic [1:0]      wv;
    logic [1:0][4:0] wa;
    logic            ex_stall;
    logic            flush;
    logic [1:0]      wbv;
    logic [1:0][4:0] wba;
    logic [1:0]      issue_o;
`ifdef DISPATCH_SCHED_PERF_EN
    logic [31:0]     stall_cycles_o;
`endif

    always #5 clk = ~clk;

    dispatch_sched #(.DECODE_WIDTH(2), .FLUSH_DRAIN(FD)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .id_valid_i           (id_valid),
        .id_reg_read_valid_i  (rv),
        .id_reg_read_addr_i   (ra),
        .id_reg_write_valid_i (wv),
        .id_reg_write_addr_i  (wa),
        .ex_stall_i           (ex_stall),
        .flush_i              (flush),
        .wb_valid_i           (wbv),
        .wb_addr_i            (wba),
        .issue_o              (issue_o)
`ifdef DISPATCH_SCHED_PERF_EN
        ,
        .stall_cycles_o       (stall_cycles_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit [31:0]   m_busy;
    int          m_drain;
    int unsigned m_perf;

    typedef struct {
        logic [1:0]      v;
        logic [1:0][1:0] rv;
        logic [1:0][9:0] ra;
        logic [1:0]      wv;
        logic [1:0][4:0] wa;
        logic            st;
        logic            fl;
        logic [1:0]      wbv;
        logic [1:0][4:0] wba;
        logic [1:0]      exp;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mkv(logic [1:0] v, logic [3:0] r,
                                 logic [4:0] s0r1, logic [4:0] s0r2,
                                 logic [4:0] s1r1, logic [4:0] s1r2,
                                 logic [1:0] w, logic [4:0] w0, logic [4:0] w1,
                                 logic st, logic fl, logic [1:0] b,
                                 logic [4:0] b0, logic [4:0] b1, logic [1:0] e);
        vec_t t;
        t.v = v; t.rv = r; t.ra = {s1r2, s1r1, s0r2, s0r1};
        t.wv = w; t.wa = {w1, w0}; t.st = st; t.fl = fl;
        t.wbv = b; t.wba = {b1, b0}; t.exp = e;
        return t;
    endfunction

    // Issue grants from the rules: hazards, pair conflict, stall, drain window
    function automatic logic [1:0] model_issue();
        logic [1:0] g;
        logic [1:0] haz;
        logic       conf;
        logic [4:0] a;
        g = 2'b00; haz = 2'b00; conf = 1'b0;
        if (rst) return 2'b00;
        for (int s = 0; s < 2; s++)
            for (int j = 0; j < 2; j++) begin
                a = ra[s][5*j +: 5];
                if (rv[s][j] && a != 5'd0 && m_busy[a]) haz[s] = 1'b1;
            end
        if (wv[0] && wa[0] != 5'd0) begin
            for (int j = 0; j < 2; j++)
                if (rv[1][j] && ra[1][5*j +: 5] == wa[0]) conf = 1'b1;
            if (wv[1] && wa[1] == wa[0]) conf = 1'b1;
        end
        g[0] = id_valid[0] && !haz[0] && !ex_stall && (m_drain == 0);
        g[1] = g[0] && id_valid[1] && !haz[1] && !conf;
        return g;
    endfunction

    task automatic model_advance(input logic [1:0] g);
        if (rst) begin
            m_busy = '0; m_drain = 0; m_perf = 0;
            return;
        end
        if (id_valid[0] && !g[0] && m_perf != 32'hFFFF_FFFF) m_perf++;
        if (flush) begin
            m_busy  = '0;
            m_drain = FD;
        end else begin
            for (int k = 0; k < 2; k++) if (wbv[k]) m_busy[wba[k]] = 1'b0;
            for (int s = 0; s < 2; s++) if (g[s] && wv[s] && wa[s] != 5'd0) m_busy[wa[s]] = 1'b1;
            m_busy[0] = 1'b0;
            if (m_drain > 0) m_drain--;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = '0; rv = '0; ra = '0; wv = '0; wa = '0;
        ex_stall = 1'b0; flush = 1'b0; wbv = '0; wba = '0;
    endtask

    task automatic apply(input vec_t t);
        id_valid = t.v; rv = t.rv; ra = t.ra; wv = t.wv; wa = t.wa;
        ex_stall = t.st; flush = t.fl; wbv = t.wbv; wba = t.wba;
    endtask

    // One cycle: sample at the falling edge, then advance the model past the rising edge
    task automatic step(input logic use_exp, input logic [1:0] exp, input string name);
        logic [1:0] m;
        @(negedge clk);
        m = model_issue();
        check({name, " model"}, 32'(issue_o), 32'(m));
        if (use_exp) check({name, " vec"}, 32'(issue_o), 32'(exp));
`ifdef DISPATCH_SCHED_PERF_EN
        check({name, " perf"}, stall_cycles_o, m_perf);
`endif
        model_advance(m);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rv bit order {s1src2, s1src1, s0src2, s0src1}
        tbl[0]  = mkv(2'b11, 4'b0100, 0, 0, 5, 0, 2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 2'b01);
        tbl[1]  = mkv(2'b11, 4'b0010, 0, 5, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
        tbl[2]  = mkv(2'b11, 4'b0100, 0, 0, 5, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01);
        tbl[3]  = mkv(2'b01, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 5, 2'b00);
        tbl[4]  = mkv(2'b11, 4'b0001, 5, 0, 0, 0, 2'b10, 0, 9, 0, 0, 2'b00, 0, 0, 2'b11);
        tbl[5]  = mkv(2'b01, 4'b0000, 0, 0, 0, 0, 2'b01, 9, 0, 0, 0, 2'b01, 9, 0, 2'b01);
        tbl[6]  = mkv(2'b01, 4'b0001, 9, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
        tbl[7]  = mkv(2'b11, 4'b0100, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 0, 0, 2'b11);
        tbl[8]  = mkv(2'b11, 4'b0000, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0, 2'b00, 0, 0, 2'b01);
        tbl[9]  = mkv(2'b01, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 0, 0, 2'b00);
        tbl[10] = mkv(2'b11, 4'b0000, 0, 0, 0, 0, 2'b10, 0, 12, 0, 1, 2'b00, 0, 0, 2'b11);
        tbl[11] = mkv(2'b01, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
        tbl[12] = mkv(2'b01, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
        tbl[13] = mkv(2'b11, 4'b1011, 9, 3, 0, 12, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b11);
        tbl[14] = mkv(2'b10, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);

        m_busy = '0; m_drain = 0; m_perf = 0;
        clear_inputs();
        rst = 1'b1;
        #1;
        // Grants held low during reset even with clean valid slots
        id_valid = 2'b11;
        step(1'b1, 2'b00, "reset_gate");
        step(1'b1, 2'b00, "reset_gate2");
        rst = 1'b0;
        clear_inputs();
        id_valid = 2'b01;
        step(1'b1, 2'b01, "post_reset_run");

        // Vector table
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i]);
            step(1'b1, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Writeback on port 0 releases a hazard only from the next cycle
        clear_inputs(); id_valid = 2'b01; wv = 2'b01; wa[0] = 5'd7;
        step(1'b1, 2'b01, "set_r7");
        clear_inputs(); id_valid = 2'b01; rv[0] = 2'b01; ra[0] = 10'd7; wbv = 2'b01; wba[0] = 5'd7;
        step(1'b1, 2'b00, "wb_r7_same");
        wbv = 2'b00;
        step(1'b1, 2'b01, "wb_r7_next");

        // Reset in the middle of a drain leaves no residual drain cycles
        clear_inputs(); id_valid = 2'b01; flush = 1'b1;
        step(1'b1, 2'b01, "flush_pre_rst");
        flush = 1'b0; rst = 1'b1;
        step(1'b1, 2'b00, "rst_in_drain");
        rst = 1'b0;
        step(1'b1, 2'b01, "after_rst_drain");

        // Back-to-back flushes keep reloading the drain window
        flush = 1'b1;
        step(1'b1, 2'b01, "flush_a");
        step(1'b1, 2'b00, "flush_b");
        flush = 1'b0;
        step(1'b1, 2'b00, "drain_1");
        step(1'b1, 2'b00, "drain_2");
        step(1'b1, 2'b01, "drain_done");

`ifdef DISPATCH_SCHED_PERF_EN
        // Stall counter over four stalled cycles from reset
        clear_inputs(); rst = 1'b1;
        step(1'b0, 2'b00, "perf_rst");
        rst = 1'b0; id_valid = 2'b01; ex_stall = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, "perf_stall");
        clear_inputs();
        @(negedge clk);
        check("perf_count4", stall_cycles_o, 32'd4);
        @(posedge clk); #1;
`endif

        // Random traffic against the model, small register range for frequent hazards
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            id_valid = 2'($urandom);
            rv       = 4'($urandom);
            for (int s = 0; s < 2; s++) begin
                ra[s] = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
                wa[s] = 5'($urandom_range(0, 7));
                wba[s] = 5'($urandom_range(0, 7));
            end
            wv       = 2'($urandom);
            wbv      = 2'($urandom);
            ex_stall = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 31) == 0);
            step(1'b0, 2'b00, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
